// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - reorder buffer sizing, issue type codes and entry layout
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 16;
  localparam int ROB_W    = 4;

  typedef logic [ROB_W-1:0] rob_id_t;

  typedef enum logic [1:0] {
    ROB_T_REG  = 2'd0,
    ROB_T_BR   = 2'd1,
    ROB_T_ST   = 2'd2,
    ROB_T_JALR = 2'd3
  } rob_type_e;

  // Decoder needs one cycle to see rob_full, so full is raised one slot early
  localparam logic [ROB_W:0] ROB_FULL_MARK = (ROB_W+1)'(ROB_SIZE - 1);

  typedef struct packed {
    logic        busy;
    logic        ready;
    rob_type_e   rtype;
    logic [4:0]  rd;
    logic        pred_taken;
    logic [31:0] value;
    logic [31:0] alt_pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - issue, writeback, lookup and retire signals of the reorder buffer
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic        is_issue;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_alt_pc;
  logic        issue_pred_taken;
  logic        issue_ready;
  logic [31:0] issue_value;
  rob_id_t     rob_tail_id;
  logic        rob_full;

  logic        rs_has_output;
  rob_id_t     rs_rob_id;
  logic [31:0] rs_output;
  logic        is_lsb;
  rob_id_t     lsb_rob_id;
  logic [31:0] lsb_res;

  rob_id_t     q1_id;
  rob_id_t     q2_id;
  logic        q1_ready;
  logic        q2_ready;
  logic [31:0] q1_value;
  logic [31:0] q2_value;

  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  rob_id_t     commit_rob_id;
  logic        commit_store;
  logic        rob_clear;
  logic [31:0] clear_pc;

  modport slave (
    input  is_issue, issue_type, issue_rd, issue_alt_pc, issue_pred_taken,
           issue_ready, issue_value,
           rs_has_output, rs_rob_id, rs_output, is_lsb, lsb_rob_id, lsb_res,
           q1_id, q2_id,
    output rob_tail_id, rob_full, q1_ready, q2_ready, q1_value, q2_value,
           commit_valid, commit_rd, commit_value, commit_rob_id, commit_store,
           rob_clear, clear_pc
  );

  modport master (
    output is_issue, issue_type, issue_rd, issue_alt_pc, issue_pred_taken,
           issue_ready, issue_value,
           rs_has_output, rs_rob_id, rs_output, is_lsb, lsb_rob_id, lsb_res,
           q1_id, q2_id,
    input  rob_tail_id, rob_full, q1_ready, q2_ready, q1_value, q2_value,
           commit_valid, commit_rd, commit_value, commit_rob_id, commit_store,
           rob_clear, clear_pc
  );

endinterface

// File: rtl/reorder_buffer_lookup.sv
// rtl/reorder_buffer_lookup.sv - operand read of one ROB entry with same-cycle writeback bypass
module reorder_buffer_lookup
  import reorder_buffer_pkg::*;
(
  input  rob_id_t             q_id,
  input  logic [ROB_SIZE-1:0] ent_ready,
  input  logic [31:0]         ent_value [ROB_SIZE],
  input  logic                rs_has_output,
  input  rob_id_t             rs_rob_id,
  input  logic [31:0]         rs_output,
  input  logic                is_lsb,
  input  rob_id_t             lsb_rob_id,
  input  logic [31:0]         lsb_res,
  output logic                q_ready,
  output logic [31:0]         q_value
);

  always_comb begin
    q_ready = ent_ready[q_id];
    q_value = ent_value[q_id];
    if (rs_has_output && rs_rob_id == q_id) begin
      q_ready = 1'b1;
      q_value = rs_output;
    end
    // LSB result overrides the ALU, matching the priority used when storing
    if (is_lsb && lsb_rob_id == q_id) begin
      q_ready = 1'b1;
      q_value = lsb_res;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order retirement buffer with branch flush
// Optional ROB_PERF_EN adds perf_commits / perf_mispredicts counters.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  reorder_buffer_if.slave   rob
`ifdef ROB_PERF_EN
  ,
  output logic [31:0]       perf_commits,
  output logic [31:0]       perf_mispredicts
`endif
);

  rob_entry_t       ent [ROB_SIZE];
  rob_id_t          head;
  rob_id_t          tail;
  logic [ROB_W:0]   count;
  logic [ROB_W:0]   count_next;
  logic             full_q;

  rob_entry_t       head_ent;
  logic             do_commit;
  logic             mispredict;
  logic             do_clear;
  logic             do_issue;

  logic [ROB_SIZE-1:0] ready_vec;
  logic [31:0]         value_arr [ROB_SIZE];

  assign head_ent   = ent[head];
  assign do_commit  = rdy_in && head_ent.busy && head_ent.ready;
  assign mispredict = (head_ent.rtype == ROB_T_BR) && (head_ent.value[0] != head_ent.pred_taken);
  assign do_clear   = do_commit && mispredict;
  assign do_issue   = rdy_in && rob.is_issue && !full_q && !do_clear;
  assign count_next = count + {{ROB_W{1'b0}}, do_issue} - {{ROB_W{1'b0}}, do_commit};

  assign rob.rob_tail_id = tail;
  assign rob.rob_full    = full_q;

  always_comb begin
    rob.commit_valid  = 1'b0;
    rob.commit_rd     = '0;
    rob.commit_value  = '0;
    rob.commit_rob_id = '0;
    rob.commit_store  = 1'b0;
    rob.rob_clear     = 1'b0;
    rob.clear_pc      = '0;
    if (do_commit) begin
      case (head_ent.rtype)
        ROB_T_REG, ROB_T_JALR: begin
          rob.commit_valid  = 1'b1;
          rob.commit_rd     = head_ent.rd;
          rob.commit_value  = head_ent.value;
          rob.commit_rob_id = head;
        end
        ROB_T_ST: rob.commit_store = 1'b1;
        ROB_T_BR: begin
          rob.rob_clear = mispredict;
          rob.clear_pc  = mispredict ? head_ent.alt_pc : 32'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      full_q <= 1'b0;
      for (int i = 0; i < ROB_SIZE; i++) ent[i] <= '0;
    end else if (rdy_in) begin
      if (do_clear) begin
        head   <= '0;
        tail   <= '0;
        count  <= '0;
        full_q <= 1'b0;
        for (int i = 0; i < ROB_SIZE; i++) begin
          ent[i].busy  <= 1'b0;
          ent[i].ready <= 1'b0;
        end
      end else begin
        if (rob.rs_has_output && ent[rob.rs_rob_id].busy) begin
          ent[rob.rs_rob_id].ready <= 1'b1;
          ent[rob.rs_rob_id].value <= rob.rs_output;
        end
        // Later assignment wins, giving the LSB priority on a shared id
        if (rob.is_lsb && ent[rob.lsb_rob_id].busy) begin
          ent[rob.lsb_rob_id].ready <= 1'b1;
          ent[rob.lsb_rob_id].value <= rob.lsb_res;
        end
        if (do_issue) begin
          ent[tail] <= '{busy:       1'b1,
                         ready:      rob.issue_ready,
                         rtype:      rob_type_e'(rob.issue_type),
                         rd:         rob.issue_rd,
                         pred_taken: rob.issue_pred_taken,
                         value:      rob.issue_value,
                         alt_pc:     rob.issue_alt_pc};
          tail <= tail + rob_id_t'(1);
        end
        if (do_commit) begin
          ent[head].busy <= 1'b0;
          head <= head + rob_id_t'(1);
        end
        count  <= count_next;
        full_q <= (count_next >= ROB_FULL_MARK);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      ready_vec[i] = ent[i].ready;
      value_arr[i] = ent[i].value;
    end
  end

  reorder_buffer_lookup u_lookup_q1 (
    .q_id          (rob.q1_id),
    .ent_ready     (ready_vec),
    .ent_value     (value_arr),
    .rs_has_output (rob.rs_has_output),
    .rs_rob_id     (rob.rs_rob_id),
    .rs_output     (rob.rs_output),
    .is_lsb        (rob.is_lsb),
    .lsb_rob_id    (rob.lsb_rob_id),
    .lsb_res       (rob.lsb_res),
    .q_ready       (rob.q1_ready),
    .q_value       (rob.q1_value)
  );

  reorder_buffer_lookup u_lookup_q2 (
    .q_id          (rob.q2_id),
    .ent_ready     (ready_vec),
    .ent_value     (value_arr),
    .rs_has_output (rob.rs_has_output),
    .rs_rob_id     (rob.rs_rob_id),
    .rs_output     (rob.rs_output),
    .is_lsb        (rob.is_lsb),
    .lsb_rob_id    (rob.lsb_rob_id),
    .lsb_res       (rob.lsb_res),
    .q_ready       (rob.q2_ready),
    .q_value       (rob.q2_value)
  );

`ifdef ROB_PERF_EN
  // Statistics survive a flush; only reset clears them
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      perf_commits     <= '0;
      perf_mispredicts <= '0;
    end else if (rdy_in) begin
      if (do_commit) perf_commits     <= perf_commits + 32'd1;
      if (do_clear)  perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule
